leds_pattern_fsm: RTL and testbench



---
 rtl/leds_pattern_fsm_pkg.sv | 33 +++
 rtl/leds_pattern_fsm.sv | 90 +++++++++
 tb/tb_leds_pattern_fsm.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/leds_pattern_fsm_pkg.sv
// Shared LED pattern definitions: mode and direction encodings plus the
// per-mode initial pattern used on reset, mode change and recovery.
package leds_pattern_fsm_pkg;

  localparam int MAX_LEDS = 64;

  typedef enum logic [1:0] {
    MODE_ROT_L    = 2'b00,
    MODE_ROT_R    = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_BLINK    = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Returned MAX_LEDS wide; callers size-cast down to their own LED count.
  function automatic logic [MAX_LEDS-1:0] init_pattern(input mode_t mode, input int nb_leds);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      unique case (mode)
        MODE_ROT_R: p[i] = (i == nb_leds - 1);
        MODE_BLINK: p[i] = (i < nb_leds);
        default:    p[i] = (i == 0);
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/leds_pattern_fsm.sv
// LED pattern sequencer: each accepted tick advances or reloads a registered
// pattern in one of four modes; o_cycle pulses when a pattern period completes.
module leds_pattern_fsm
  import leds_pattern_fsm_pkg::*;
#(
  parameter int NB_LEDS = 4,
  parameter int NB_MODE = 2
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_cycle
);

  logic [NB_LEDS-1:0] led, led_nxt, led_init;
  mode_t              mode, mode_nxt, mode_in;
  dir_t               dir, dir_nxt;
  logic               cycle, cycle_nxt;
  logic               tick;
  logic               pattern_ok;

  assign tick    = i_valid & i_enable;
  assign mode_in = mode_t'(i_mode);

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      led   <= NB_LEDS'(1);
      mode  <= MODE_ROT_L;
      dir   <= DIR_LEFT;
      cycle <= 1'b0;
    end else begin
      led   <= led_nxt;
      mode  <= mode_nxt;
      dir   <= dir_nxt;
      cycle <= cycle_nxt;
    end
  end

  always_comb begin
    led_nxt    = led;
    mode_nxt   = mode;
    dir_nxt    = dir;
    cycle_nxt  = 1'b0;
    led_init   = NB_LEDS'(init_pattern(mode_in, NB_LEDS));
    pattern_ok = (mode == MODE_BLINK) ? ((led == '0) || (led == '1)) : $onehot(led);

    if (tick) begin
      // A mode change and a corrupted pattern both restart from the mode's init pattern.
      if ((mode_in != mode) || !pattern_ok) begin
        mode_nxt = mode_in;
        led_nxt  = led_init;
        dir_nxt  = DIR_LEFT;
      end else begin
        unique case (mode)
          MODE_ROT_L: begin
            led_nxt   = {led[NB_LEDS-2:0], led[NB_LEDS-1]};
            cycle_nxt = (led_nxt == NB_LEDS'(1));
          end
          MODE_ROT_R: begin
            led_nxt   = {led[0], led[NB_LEDS-1:1]};
            cycle_nxt = (led_nxt == {1'b1, {(NB_LEDS-1){1'b0}}});
          end
          MODE_PINGPONG: begin
            if (dir == DIR_LEFT) begin
              led_nxt = led << 1;
              if (led_nxt[NB_LEDS-1]) dir_nxt = DIR_RIGHT;
            end else begin
              led_nxt = led >> 1;
              if (led_nxt[0]) begin
                dir_nxt   = DIR_LEFT;
                cycle_nxt = 1'b1;
              end
            end
          end
          MODE_BLINK: begin
            led_nxt   = ~led;
            cycle_nxt = (led_nxt == '1);
          end
        endcase
      end
    end
  end

  assign o_led   = led;
  assign o_cycle = cycle;

endmodule

// File: tb/tb_leds_pattern_fsm.sv
// Bench for leds_pattern_fsm: phase-based model checked every cycle plus
// directed tick sequences with literal expectations.
module tb_leds_pattern_fsm;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_enable = 1'b0;
  logic [1:0]   i_mode = 2'b00;
  logic [N-1:0] o_led;
  logic         o_cycle;

  int n_vec = 0;
  int n_err = 0;

  leds_pattern_fsm #(.NB_LEDS(N), .NB_MODE(2)) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_enable (i_enable),
    .i_mode   (i_mode),
    .o_led    (o_led),
    .o_cycle  (o_cycle)
  );

  always #5 clock = ~clock;

  // Model: a mode plus a phase within that mode's period; the pattern is derived from the phase.
  int m_mode  = 0;
  int m_phase = 0;
  int m_cycle = 0;

  function automatic int period(input int mode);
    case (mode)
      2:       return 2 * (N - 1);
      3:       return 2;
      default: return N;
    endcase
  endfunction

  function automatic logic [31:0] model_led(input int mode, input int phase);
    int pos;
    case (mode)
      0: return 32'(1) << phase;
      1: return 32'(1) << (N - 1 - phase);
      2: begin
        pos = (phase < N) ? phase : 2 * (N - 1) - phase;
        return 32'(1) << pos;
      end
      default: return (phase == 0) ? 32'((1 << N) - 1) : 32'(0);
    endcase
  endfunction

  always @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      m_mode  = 0;
      m_phase = 0;
      m_cycle = 0;
    end else begin
      m_cycle = 0;
      if (i_valid && i_enable) begin
        if (int'(i_mode) != m_mode) begin
          m_mode  = int'(i_mode);
          m_phase = 0;
        end else begin
          m_phase = (m_phase + 1) % period(m_mode);
          m_cycle = (m_phase == 0) ? 1 : 0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("model led", 32'(o_led), model_led(m_mode, m_phase));
    check("model cycle", 32'(o_cycle), 32'(m_cycle));
  end

  // Drive one cycle at the falling edge, then check literals just after the rising edge.
  task automatic step(input string nm, input logic v, input logic e, input logic [1:0] m,
                      input logic [N-1:0] el, input logic ec);
    @(negedge clock);
    i_valid  = v;
    i_enable = e;
    i_mode   = m;
    @(posedge clock);
    #1;
    check({nm, " led"}, 32'(o_led), 32'(el));
    check({nm, " cycle"}, 32'(o_cycle), 32'(ec));
  endtask

  initial begin
    #1 i_reset = 1'b1;
    #2;
    check("reset led", 32'(o_led), 32'h1);
    check("reset cycle", 32'(o_cycle), 32'h0);
    repeat (2) @(negedge clock);
    i_reset = 1'b0;

    // Rotate left from reset, with an idle cycle in between that must hold.
    step("rotl1", 1, 1, 2'b00, 4'b0010, 0);
    step("rotl idle", 0, 1, 2'b00, 4'b0010, 0);
    step("rotl2", 1, 1, 2'b00, 4'b0100, 0);
    step("rotl3", 1, 1, 2'b00, 4'b1000, 0);
    step("rotl4", 1, 1, 2'b00, 4'b0001, 1);

    // Ping-pong: mode change loads, then a full period.
    step("pp load", 1, 1, 2'b10, 4'b0001, 0);
    step("pp1", 1, 1, 2'b10, 4'b0010, 0);
    step("pp2", 1, 1, 2'b10, 4'b0100, 0);
    step("pp3", 1, 1, 2'b10, 4'b1000, 0);
    step("pp4", 1, 1, 2'b10, 4'b0100, 0);
    step("pp5", 1, 1, 2'b10, 4'b0010, 0);
    step("pp6", 1, 1, 2'b10, 4'b0001, 1);

    // Back to rotate left up to 0100, then blink.
    step("rotl load", 1, 1, 2'b00, 4'b0001, 0);
    step("rotl a", 1, 1, 2'b00, 4'b0010, 0);
    step("rotl b", 1, 1, 2'b00, 4'b0100, 0);
    step("mode idle", 0, 1, 2'b11, 4'b0100, 0);
    step("blink load", 1, 1, 2'b11, 4'b1111, 0);
    step("blink1", 1, 1, 2'b11, 4'b0000, 0);
    step("blink2", 1, 1, 2'b11, 4'b1111, 1);

    // Disabled: ticks and mode toggling are ignored.
    for (int i = 0; i < 10; i++)
      step("frozen", 1, 0, (i % 2 == 0) ? 2'b01 : 2'b10, 4'b1111, 0);

    // Re-enable with rotate right: load, then valid held high for four cycles.
    step("rotr load", 1, 1, 2'b01, 4'b1000, 0);
    step("rotr1", 1, 1, 2'b01, 4'b0100, 0);
    step("rotr2", 1, 1, 2'b01, 4'b0010, 0);
    step("rotr3", 1, 1, 2'b01, 4'b0001, 0);
    step("rotr4", 1, 1, 2'b01, 4'b1000, 1);

    // Ping-pong to 1000 (direction now right), then asynchronous reset mid-cycle.
    step("pp2 load", 1, 1, 2'b10, 4'b0001, 0);
    step("pp2 a", 1, 1, 2'b10, 4'b0010, 0);
    step("pp2 b", 1, 1, 2'b10, 4'b0100, 0);
    step("pp2 c", 1, 1, 2'b10, 4'b1000, 0);
    @(negedge clock);
    i_valid = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    check("async reset led", 32'(o_led), 32'h1);
    check("async reset cycle", 32'(o_cycle), 32'h0);
    @(negedge clock);
    i_reset = 1'b0;
    step("post reset", 1, 1, 2'b00, 4'b0010, 0);

    // Blink entered from rotate right, then leave mid-period.
    step("rotr2 load", 1, 1, 2'b01, 4'b1000, 0);
    step("blink2 load", 1, 1, 2'b11, 4'b1111, 0);
    step("blink2 a", 1, 1, 2'b11, 4'b0000, 0);
    step("pp3 load", 1, 1, 2'b10, 4'b0001, 0);
    step("pp3 a", 1, 1, 2'b10, 4'b0010, 0);

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
